// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide. Signed ops run on
// magnitudes and get their signs fixed up in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;     // product / quotient negated
  logic                 rneg_q, rneg_d;   // remainder negated (dividend sign)
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // {high/remainder, low/quotient}
  logic [WIDTH-1:0]     srca_q, srca_d;   // raw dividend for divide-by-zero
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, rem_shift, trial;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand magnitudes, per-iteration arithmetic and sign-corrected results
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & srca[WIDTH-1];
    b_neg     = is_signed & srcb[WIDTH-1];
    mag_a     = a_neg ? -srca : srca;
    mag_b     = b_neg ? -srcb : srcb;
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Partial remainder shifted left with the next dividend bit brought in
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, opnd_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: FSM, iteration datapath and HI/LO writes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    srca_d   = srca_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = mt_data;
        if (lo_we) lo_d = mt_data;
        if (start) begin
          state_d  = StRun;
          cnt_d    = CntW'(WIDTH);
          busy_d   = 1'b1;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          srca_d   = srca;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (opnd_q == {WIDTH{1'b0}}) begin
            hi_d = srca_q;
            lo_d = {WIDTH{1'b1}};
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      srca_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      srca_q   <= srca_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
